mem_access: RTL

- Memory stage of the 5-stage pipeline; consumes `dataE` from the execute→memory pipeline register.
- Turns loads and stores into data-bus transactions and holds the transaction until it completes.
- Aligns and extends load data, then produces `dataM` for the memory→writeback register.
- Drives `stall_m` and `dbus_not_busy`, so the hazard unit and pipeline registers never flush or re-issue an in-flight access.

---
 rtl/mem_access_pkg.sv | 58 +++++
 rtl/mem_access_if.sv | 28 ++
 rtl/mem_access_align.sv | 52 +++++
 rtl/mem_access.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
`default_nettype none
// =============================================================================
// mem_access_pkg : shared types, size codes and helpers for the memory stage
// Revision       : 1.0
// =============================================================================
package mem_access_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 64;
    localparam int STRB_W = 8;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [63:0]       pc;
        logic [4:0]        rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        msize_t            msize;
        logic              mem_unsigned;
        logic [ADDR_W-1:0] alu_out;
        logic [DATA_W-1:0] wdata;
    } execute_data_t;

    typedef struct packed {
        logic              valid;
        logic [63:0]       pc;
        logic [4:0]        rd;
        logic              reg_write;
        logic              mem_read;
        logic              misalign;
        logic [DATA_W-1:0] alu_out;
    } memory_data_t;

    function automatic logic is_misaligned(input msize_t size, input logic [2:0] addr_lo);
        case (size)
            MSIZE2:  return addr_lo[0];
            MSIZE4:  return |addr_lo[1:0];
            MSIZE8:  return |addr_lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_if.sv
`default_nettype none
// =============================================================================
// mem_access_if : data-bus request/response bundle between memory stage and bus
// Revision      : 1.0
// =============================================================================
interface mem_access_if;
    import mem_access_pkg::*;

    logic              dreq_valid;
    logic [ADDR_W-1:0] dreq_addr;
    msize_t            dreq_size;
    logic [STRB_W-1:0] dreq_strobe;
    logic [DATA_W-1:0] dreq_data;
    logic              dresp_data_ok;
    logic [DATA_W-1:0] dresp_data;

    modport master (
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  dresp_data_ok, dresp_data
    );

    modport slave (
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output dresp_data_ok, dresp_data
    );

endinterface
`default_nettype wire

// File: rtl/mem_access_align.sv
`default_nettype none
// =============================================================================
// mem_align : byte-lane placement of store data and extraction/extension of loads
// Revision  : 1.0
// =============================================================================
module mem_align
    import mem_access_pkg::*;
(
    input  logic [2:0]        addr_lo_i,
    input  msize_t            size_i,
    input  logic              unsigned_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [STRB_W-1:0] strobe_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic [5:0]        bit_sh;
    logic [STRB_W-1:0] mask;
    logic [DATA_W-1:0] raw;
    logic              sext;

    assign bit_sh = {addr_lo_i, 3'b000};
    assign sext   = ~unsigned_i;

    always_comb begin
        mask = 8'hFF;
        case (size_i)
            MSIZE1:  mask = 8'h01;
            MSIZE2:  mask = 8'h03;
            MSIZE4:  mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
    end

    assign strobe_o = mask << addr_lo_i;
    assign wdata_o  = wdata_i << bit_sh;
    assign raw      = rdata_i >> bit_sh;

    always_comb begin
        rdata_o = raw;
        case (size_i)
            MSIZE1:  rdata_o = {{56{raw[7]  & sext}}, raw[7:0]};
            MSIZE2:  rdata_o = {{48{raw[15] & sext}}, raw[15:0]};
            MSIZE4:  rdata_o = {{32{raw[31] & sext}}, raw[31:0]};
            default: rdata_o = raw;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// =============================================================================
// mem_access : memory pipeline stage; issues one bus transaction per load/store
// Revision   : 1.0
// =============================================================================
module mem_access
    import mem_access_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  execute_data_t dataE,
    input  logic          advance,
    mem_access_if.master  dbus,
    output memory_data_t  dataM,
    output logic          stall_m,
    output logic          dbus_not_busy,
    output logic          misalign
);

    state_t            state_q, state_d;
    execute_data_t     req_q, req_d;
    memory_data_t      res_q, res_d;

    logic              is_idle;
    logic              mem_op;
    logic              misalign_c;
    logic              need_access;
    logic              dreq_valid_c;
    execute_data_t     src;
    logic [STRB_W-1:0] al_strobe;
    logic [DATA_W-1:0] al_wdata;
    logic [DATA_W-1:0] al_rdata;
    memory_data_t      pass_m;
    memory_data_t      load_m;

    assign is_idle     = (state_q == S_IDLE);
    assign mem_op      = dataE.valid & (dataE.mem_read | dataE.mem_write);
    assign misalign_c  = is_idle & mem_op & is_misaligned(dataE.msize, dataE.alu_out[2:0]);
    assign need_access = is_idle & mem_op & ~misalign_c;

    // Once issued, the request is replayed from the latched copy so it stays stable.
    assign src = is_idle ? dataE : req_q;

    mem_align u_align (
        .addr_lo_i  (src.alu_out[2:0]),
        .size_i     (src.msize),
        .unsigned_i (src.mem_unsigned),
        .wdata_i    (src.wdata),
        .rdata_i    (dbus.dresp_data),
        .strobe_o   (al_strobe),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata)
    );

    always_comb begin
        pass_m           = '0;
        pass_m.valid     = dataE.valid;
        pass_m.pc        = dataE.pc;
        pass_m.rd        = dataE.rd;
        pass_m.reg_write = dataE.reg_write;
        pass_m.mem_read  = dataE.mem_read;
        pass_m.misalign  = misalign_c;
        pass_m.alu_out   = dataE.alu_out;
    end

    always_comb begin
        load_m           = '0;
        load_m.valid     = src.valid;
        load_m.pc        = src.pc;
        load_m.rd        = src.rd;
        load_m.reg_write = src.reg_write;
        load_m.mem_read  = src.mem_read;
        load_m.misalign  = 1'b0;
        load_m.alu_out   = src.mem_read ? al_rdata : src.alu_out;
    end

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        res_d         = res_q;
        dreq_valid_c  = 1'b0;
        dataM         = '0;
        stall_m       = 1'b0;
        dbus_not_busy = 1'b1;
        case (state_q)
            S_IDLE: begin
                dataM = pass_m;
                if (need_access) begin
                    dreq_valid_c = 1'b1;
                    req_d        = dataE;
                    if (dbus.dresp_data_ok) begin
                        // Consumed this cycle when advance is high; otherwise park in DONE.
                        res_d   = load_m;
                        dataM   = load_m;
                        state_d = advance ? S_IDLE : S_DONE;
                    end else begin
                        dataM         = '0;
                        stall_m       = 1'b1;
                        dbus_not_busy = 1'b0;
                        state_d       = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                dreq_valid_c  = 1'b1;
                stall_m       = 1'b1;
                dbus_not_busy = 1'b0;
                if (dbus.dresp_data_ok) begin
                    res_d   = load_m;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                dataM = res_q;
                if (advance) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            res_q   <= res_d;
        end
    end

    assign dbus.dreq_valid  = dreq_valid_c;
    assign dbus.dreq_addr   = src.alu_out;
    assign dbus.dreq_size   = src.msize;
    assign dbus.dreq_strobe = src.mem_write ? al_strobe : '0;
    assign dbus.dreq_data   = al_wdata;
    assign misalign         = misalign_c;

endmodule
`default_nettype wire
